// File: rtl/multi_channel_fifo.sv
// multi_channel_fifo: multi-lane push / multi-lane pop FIFO over a small
// distributed-RAM array. Up to IN_WIDTH entries enter and up to OUT_WIDTH
// entries leave per cycle, each side accepting an in-order prefix of lanes.
// A count register tracks occupancy so every one of the DEPTH slots is usable.
//
// Build option: define MULTI_CHANNEL_FIFO_BYPASS_EN to let accepted pushes
// appear on idle pop lanes in the same cycle. Without it, pushed data reaches
// the pop side one cycle after the accepting edge.
module multi_channel_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 8,
  parameter int IN_WIDTH   = 2,
  parameter int OUT_WIDTH  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [IN_WIDTH-1:0]                   push_valid,
  input  logic [IN_WIDTH-1:0][DATA_WIDTH-1:0]   push_data,
  output logic [IN_WIDTH-1:0]                   push_ready,
  output logic [OUT_WIDTH-1:0]                  pop_valid,
  output logic [OUT_WIDTH-1:0][DATA_WIDTH-1:0]  pop_data,
  input  logic [OUT_WIDTH-1:0]                  pop_ready,
  output logic [$clog2(DEPTH):0]                count,
  output logic                                  full,
  output logic                                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  // Storage and state. The RAM is deliberately left unreset.
  logic [DATA_WIDTH-1:0] ram_r [DEPTH];
  logic [PW-1:0]         write_ptr_r;
  logic [PW-1:0]         read_ptr_r;
  logic [CW-1:0]         count_r;

  // Push-side decode
  logic [CW-1:0]         free_s;
  logic [IN_WIDTH-1:0]   push_ready_s;
  logic [IN_WIDTH-1:0]   push_acc_s;
  logic                  push_run_s;
  logic [CW-1:0]         n_push_s;

  // Pop-side decode
  logic [OUT_WIDTH-1:0]                 pop_valid_s;
  logic [OUT_WIDTH-1:0][DATA_WIDTH-1:0] pop_data_s;
  logic                                 pop_run_s;
  logic [CW-1:0]                        n_pop_s;
  logic                                 byp_hit_s;

  // Bookkeeping for the next state
  logic [CW-1:0]         n_byp_s;
  logic [CW-1:0]         wr_adv_s;
  logic [CW-1:0]         rd_adv_s;
  logic [CW-1:0]         count_nxt_s;
  logic [IN_WIDTH-1:0]   wr_en_s;
  logic [PW-1:0]         wr_addr_s [IN_WIDTH];

  // Push readiness comes only from the registered count; acceptance is the
  // in-order prefix of valid&ready lanes, so a gap stops all higher lanes.
  always_comb begin
    free_s     = CNT_DEPTH - count_r;
    push_run_s = 1'b1;
    n_push_s   = CNT_ZERO;
    for (int i = 0; i < IN_WIDTH; i++) begin
      push_ready_s[i] = (int'(free_s) > i);
      push_run_s      = push_run_s & push_valid[i] & push_ready_s[i];
      push_acc_s[i]   = push_run_s;
      n_push_s        = n_push_s + (push_run_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // Pop lanes read the RAM combinationally starting at read_ptr; with bypass
  // enabled, lanes beyond the stored entries pick up accepted push lanes.
  always_comb begin
    byp_hit_s = 1'b0;
    for (int j = 0; j < OUT_WIDTH; j++) begin
      pop_valid_s[j] = (int'(count_r) > j);
      pop_data_s[j]  = ram_r[read_ptr_r + PW'(j)];
`ifdef MULTI_CHANNEL_FIFO_BYPASS_EN
      for (int k = 0; k < IN_WIDTH; k++) begin
        byp_hit_s      = ((int'(count_r) + k) == j) && push_acc_s[k];
        pop_valid_s[j] = pop_valid_s[j] | byp_hit_s;
        pop_data_s[j]  = byp_hit_s ? push_data[k] : pop_data_s[j];
      end
`endif
    end
  end

  // Pop acceptance is the in-order prefix of valid&ready pop lanes.
  always_comb begin
    pop_run_s = 1'b1;
    n_pop_s   = CNT_ZERO;
    for (int j = 0; j < OUT_WIDTH; j++) begin
      pop_run_s = pop_run_s & pop_valid_s[j] & pop_ready[j];
      n_pop_s   = n_pop_s + (pop_run_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // Entries popped beyond the stored ones were bypassed and are never
  // written; surviving push lanes are packed down onto write_ptr.
  always_comb begin
`ifdef MULTI_CHANNEL_FIFO_BYPASS_EN
    if (n_pop_s > count_r) begin
      n_byp_s = n_pop_s - count_r;
    end else begin
      n_byp_s = CNT_ZERO;
    end
`else
    n_byp_s = CNT_ZERO;
`endif
    wr_adv_s    = n_push_s - n_byp_s;
    rd_adv_s    = n_pop_s - n_byp_s;
    count_nxt_s = count_r + n_push_s - n_pop_s;
    for (int k = 0; k < IN_WIDTH; k++) begin
      wr_en_s[k]   = push_acc_s[k] & (CW'(k) >= n_byp_s) & ~rst & ~flush;
      wr_addr_s[k] = write_ptr_r + PW'(k) - n_byp_s[PW-1:0];
    end
  end

  // RAM write port: one write per surviving accepted push lane.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_WIDTH; k++) begin
      if (wr_en_s[k]) begin
        ram_r[wr_addr_s[k]] <= push_data[k];
      end
    end
  end

  // Pointer and occupancy update; reset and flush win over any traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      write_ptr_r <= {PW{1'b0}};
      read_ptr_r  <= {PW{1'b0}};
      count_r     <= CNT_ZERO;
    end else begin
      write_ptr_r <= write_ptr_r + wr_adv_s[PW-1:0];
      read_ptr_r  <= read_ptr_r + rd_adv_s[PW-1:0];
      count_r     <= count_nxt_s;
    end
  end

  assign push_ready = push_ready_s;
  assign pop_valid  = pop_valid_s;
  assign pop_data   = pop_data_s;
  assign count      = count_r;
  assign full       = (count_r == CNT_DEPTH);
  assign empty      = (count_r == CNT_ZERO);

endmodule

// File: tb/tb_multi_channel_fifo.sv
// Directed bench for multi_channel_fifo (DATA_WIDTH=8, DEPTH=8, 2 lanes each).
module tb_multi_channel_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int IW    = 2;
  localparam int OW    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [IW-1:0]          push_valid;
  logic [IW-1:0][DW-1:0]  push_data;
  logic [IW-1:0]          push_ready;
  logic [OW-1:0]          pop_valid;
  logic [OW-1:0][DW-1:0]  pop_data;
  logic [OW-1:0]          pop_ready;
  logic [3:0]             count;
  logic                   full;
  logic                   empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp0;
  logic [DW-1:0] exp1;

  multi_channel_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst        = 1'b0;
    flush      = 1'b0;
    push_valid = 2'b00;
    pop_ready  = 2'b00;
    push_data  = 16'h0000;
  endtask

  task automatic push2(input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] v);
    push_data[0] = d0;
    push_data[1] = d1;
    push_valid   = v;
    tick();
    push_valid   = 2'b00;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (push_ready !== 2'b11) begin n_bad++; $display("FAIL reset_push_ready got %b want 11", push_ready); end
    n_cmp++; if (pop_valid !== 2'b00) begin n_bad++; $display("FAIL reset_pop_valid got %b want 00", pop_valid); end
  endtask

  task automatic test_basic();
    push_data[0] = 8'h11;
    push_data[1] = 8'h22;
    push_valid   = 2'b11;
    #1;
`ifndef MULTI_CHANNEL_FIFO_BYPASS_EN
    n_cmp++; if (pop_valid !== 2'b00) begin n_bad++; $display("FAIL basic_latency got %b want 00", pop_valid); end
`endif
    tick();
    push_valid = 2'b00;
    #1;
    n_cmp++; if (count !== 4'd2) begin n_bad++; $display("FAIL basic_count got %0d want 2", count); end
    n_cmp++; if (pop_valid !== 2'b11) begin n_bad++; $display("FAIL basic_pop_valid got %b want 11", pop_valid); end
    n_cmp++; if (pop_data[0] !== 8'h11) begin n_bad++; $display("FAIL basic_data0 got %h want 11", pop_data[0]); end
    n_cmp++; if (pop_data[1] !== 8'h22) begin n_bad++; $display("FAIL basic_data1 got %h want 22", pop_data[1]); end
    pop_ready = 2'b11;
    tick();
    pop_ready = 2'b00;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL basic_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) begin
      push2(8'(2 * c + 1), 8'(2 * c + 2), 2'b11);
    end
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d want 8", count); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (push_ready !== 2'b00) begin n_bad++; $display("FAIL fill_push_ready got %b want 00", push_ready); end
    push2(8'hEE, 8'hFF, 2'b11);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_overpush_count got %0d want 8", count); end
    for (int c = 0; c < 4; c++) begin
      exp0 = 8'(2 * c + 1);
      exp1 = 8'(2 * c + 2);
      n_cmp++; if (pop_data[0] !== exp0) begin n_bad++; $display("FAIL fill_drain_d0 got %h want %h", pop_data[0], exp0); end
      n_cmp++; if (pop_data[1] !== exp1) begin n_bad++; $display("FAIL fill_drain_d1 got %h want %h", pop_data[1], exp1); end
      pop_ready = 2'b11;
      tick();
      pop_ready = 2'b00;
      #1;
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fill_drain_empty got %b want 1", empty); end
  endtask

  task automatic test_partial();
    push2(8'h31, 8'h32, 2'b11);
    push2(8'h33, 8'h34, 2'b11);
    push2(8'h35, 8'h36, 2'b11);
    push2(8'h37, 8'h00, 2'b01);
    n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL partial_count7 got %0d want 7", count); end
    n_cmp++; if (push_ready !== 2'b01) begin n_bad++; $display("FAIL partial_push_ready got %b want 01", push_ready); end
    push2(8'h38, 8'h39, 2'b11);
    n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL partial_count8 got %0d want 8", count); end
    for (int c = 0; c < 4; c++) begin
      exp0 = 8'(8'h31 + 2 * c);
      exp1 = 8'(8'h32 + 2 * c);
      n_cmp++; if (pop_data[0] !== exp0) begin n_bad++; $display("FAIL partial_d0 got %h want %h", pop_data[0], exp0); end
      n_cmp++; if (pop_data[1] !== exp1) begin n_bad++; $display("FAIL partial_d1 got %h want %h", pop_data[1], exp1); end
      pop_ready = 2'b11;
      tick();
      pop_ready = 2'b00;
      #1;
    end
    push2(8'h66, 8'h77, 2'b10);
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL gap_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL gap_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    q.delete();
    for (int c = 0; c < 4; c++) begin
      push2(8'(8'h40 + 2 * c), 8'(8'h41 + 2 * c), 2'b11);
      q.push_back(8'(8'h40 + 2 * c));
      q.push_back(8'(8'h41 + 2 * c));
    end
    push_data[0] = 8'h90;
    push_data[1] = 8'h91;
    push_valid   = 2'b11;
    pop_ready    = 2'b11;
    #1;
    n_cmp++; if (push_ready !== 2'b00) begin n_bad++; $display("FAIL b2b_full_push_ready got %b want 00", push_ready); end
    tick();
    void'(q.pop_front());
    void'(q.pop_front());
    n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL b2b_count_after_full got %0d want 6", count); end
    for (int c = 0; c < 10; c++) begin
      push_data[0] = 8'(8'hA0 + 2 * c);
      push_data[1] = 8'(8'hA1 + 2 * c);
      push_valid   = 2'b11;
      pop_ready    = 2'b11;
      #1;
      n_cmp++; if (push_ready !== 2'b11) begin n_bad++; $display("FAIL b2b_push_ready c=%0d got %b want 11", c, push_ready); end
      n_cmp++; if (pop_data[0] !== q[0]) begin n_bad++; $display("FAIL b2b_d0 c=%0d got %h want %h", c, pop_data[0], q[0]); end
      n_cmp++; if (pop_data[1] !== q[1]) begin n_bad++; $display("FAIL b2b_d1 c=%0d got %h want %h", c, pop_data[1], q[1]); end
      tick();
      void'(q.pop_front());
      void'(q.pop_front());
      q.push_back(8'(8'hA0 + 2 * c));
      q.push_back(8'(8'hA1 + 2 * c));
      n_cmp++; if (count !== 4'd6) begin n_bad++; $display("FAIL b2b_count c=%0d got %0d want 6", c, count); end
    end
    push_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      pop_ready = 2'b11;
      #1;
      n_cmp++; if (pop_data[0] !== q[0]) begin n_bad++; $display("FAIL b2b_tail_d0 got %h want %h", pop_data[0], q[0]); end
      n_cmp++; if (pop_data[1] !== q[1]) begin n_bad++; $display("FAIL b2b_tail_d1 got %h want %h", pop_data[1], q[1]); end
      tick();
      void'(q.pop_front());
      void'(q.pop_front());
    end
    pop_ready = 2'b00;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL b2b_empty got %b want 1", empty); end
  endtask

  task automatic test_flush();
    push2(8'h51, 8'h52, 2'b11);
    push2(8'h53, 8'h54, 2'b11);
    push2(8'h55, 8'h00, 2'b01);
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL flush_pre_count got %0d want 5", count); end
    flush        = 1'b1;
    push_data[0] = 8'hD1;
    push_data[1] = 8'hD2;
    push_valid   = 2'b11;
    pop_ready    = 2'b11;
    tick();
    idle();
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL flush_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty got %b want 1", empty); end
    n_cmp++; if (pop_valid !== 2'b00) begin n_bad++; $display("FAIL flush_pop_valid got %b want 00", pop_valid); end
    n_cmp++; if (push_ready !== 2'b11) begin n_bad++; $display("FAIL flush_push_ready got %b want 11", push_ready); end
    push2(8'h5A, 8'h00, 2'b01);
    n_cmp++; if (pop_data[0] !== 8'h5A) begin n_bad++; $display("FAIL flush_repush got %h want 5a", pop_data[0]); end
    rst          = 1'b1;
    push_data[0] = 8'hC1;
    push_data[1] = 8'hC2;
    push_valid   = 2'b11;
    tick();
    idle();
    #1;
    n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL midrst_empty got %b want 1", empty); end
  endtask

`ifdef MULTI_CHANNEL_FIFO_BYPASS_EN
  task automatic test_bypass();
    push_data[0] = 8'hAA;
    push_data[1] = 8'hBB;
    push_valid   = 2'b11;
    pop_ready    = 2'b01;
    #1;
    n_cmp++; if (pop_valid !== 2'b11) begin n_bad++; $display("FAIL byp_pop_valid got %b want 11", pop_valid); end
    n_cmp++; if (pop_data[0] !== 8'hAA) begin n_bad++; $display("FAIL byp_same_cycle got %h want aa", pop_data[0]); end
    tick();
    idle();
    #1;
    n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL byp_count got %0d want 1", count); end
    n_cmp++; if (pop_data[0] !== 8'hBB) begin n_bad++; $display("FAIL byp_next got %h want bb", pop_data[0]); end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_basic();
    test_fill();
    test_partial();
    test_back_to_back();
    test_flush();
`ifdef MULTI_CHANNEL_FIFO_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_fifo.md
MULTI_CHANNEL_FIFO -- requirements
Module: multi_channel_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 128: bits per entry.
REQ-002 Parameter DEPTH, default 8: entry count; SHALL be a power of two, >=2.
REQ-003 Parameter IN_WIDTH, default 2: push lanes; 1 <= IN_WIDTH <= DEPTH.
REQ-004 Parameter OUT_WIDTH, default 2: pop lanes; 1 <= OUT_WIDTH <= DEPTH.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 flush  in  1  synchronous clear of all entries; same effect as rst.
REQ-008 push_valid  in  IN_WIDTH  per-lane push request.
REQ-009 push_data  in  IN_WIDTH x DATA_WIDTH  per-lane push payload.
REQ-010 push_ready  out  IN_WIDTH  lane i has a free slot.
REQ-011 pop_valid  out  OUT_WIDTH  lane j holds a valid entry.
REQ-012 pop_data  out  OUT_WIDTH x DATA_WIDTH  lane j payload.
REQ-013 pop_ready  in  OUT_WIDTH  consumer accepts lane j.
REQ-014 count  out  clog2(DEPTH)+1  current occupancy.
REQ-015 full / empty  out  1 each  count==DEPTH / count==0.

Function
REQ-016 Storage: DEPTH-entry distributed-RAM array; write_ptr, read_ptr each clog2(DEPTH) bits, wrap modulo DEPTH; count register tracks occupancy, so all DEPTH slots usable (no sacrificial slot).
REQ-017 push_ready[i] = (DEPTH - count) > i, from registered count only.
REQ-018 Push acceptance: lane i accepted iff push_valid[k] & push_ready[k] for all k<=i (in-order prefix); n_push = accepted lanes; lane i writes ram[write_ptr+i]; write_ptr += n_push.
REQ-019 A non-prefix valid lane (gap below it) SHALL NOT be written that cycle.
REQ-020 pop_valid[j] = count > j; pop_data[j] = ram[read_ptr+j], combinational read, zero-cycle latency.
REQ-021 Pop acceptance: in-order prefix of pop_valid[j] & pop_ready[j]; n_pop = prefix length; read_ptr += n_pop.
REQ-022 Next count = count + n_push - n_pop; simultaneous push and pop both take effect same edge; slots freed this cycle not reusable until next cycle.
REQ-023 Pushed data visible on pop side one cycle after accepting edge (without bypass, REQ-030).
REQ-024 pop_data for lanes with pop_valid=0 is don't-care; no ordering change on pointer wrap-around.
REQ-025 flush has priority over push/pop in same cycle: pointers and count to 0, push/pop that cycle discarded.

Reset
REQ-026 On rst (or flush): write_ptr=0, read_ptr=0, count=0; therefore pop_valid=0, empty=1, full=0, push_ready=all ones next cycle.
REQ-027 RAM contents SHALL NOT be reset.
REQ-028 rst mid-operation discards all entries and in-flight pushes of that cycle.

Configuration
REQ-029 Macro MULTI_CHANNEL_FIFO_BYPASS_EN selects same-cycle bypass.
REQ-030 With macro: when count < OUT_WIDTH, pop lanes j >= count are filled combinationally from accepted push lanes in order (pop_valid set, pop_data = push_data); bypassed entries popped same cycle are not stored; push acceptance still uses REQ-017/018 only (no ready->ready loop through bypass).
REQ-031 Without macro: no bypass; REQ-023 latency holds.

Verification (DATA_WIDTH=8, DEPTH=8, IN_WIDTH=2, OUT_WIDTH=2, no bypass unless stated)
REQ-032 After rst, push lanes {0x11,0x22} both valid, pop_ready=0 -> next cycle count=2, pop_data={0x11,0x22}, pop_valid=2'b11.
REQ-033 Fill with 4 double-pushes (0x01..0x08), pop_ready=0 -> count=8, full=1, push_ready=2'b00; a further push leaves count=8 and contents unchanged.
REQ-034 count=7, push_valid=2'b11 -> only lane 0 accepted, count=8; push_valid=2'b10 at count=0 -> nothing written.
REQ-035 count=8, push 2 and pop 2 same cycle -> push rejected (push_ready=0), count=6; then repeated push2/pop2 for 10 cycles crossing wrap -> data out strictly in push order, count steady.
REQ-036 count=5, flush with push_valid=2'b11 and pop_ready=2'b11 -> next cycle count=0, empty=1, pop_valid=0.
REQ-037 With MULTI_CHANNEL_FIFO_BYPASS_EN, empty FIFO, push {0xAA,0xBB}, pop_ready=2'b01 -> same cycle pop_data[0]=0xAA accepted; next cycle count=1, pop_data[0]=0xBB.
